// File: rtl/tmax_stage_buffer_if.sv
// Handshake and beat bus for tmax_stage_buffer: upstream value stream in,
// replayed group beats with group maximum out.
interface tmax_stage_buffer_if;
    logic        valid_in;
    logic [15:0] data_in;
    logic        last_in;
    logic        in_ready;
    logic        valid_out;
    logic [15:0] data_out;
    logic [15:0] Chidx_out;
    logic [15:0] Tmax;
    logic        last_out;

    modport master (
        output valid_in, data_in, last_in,
        input  in_ready, valid_out, data_out, Chidx_out, Tmax, last_out
    );

    modport slave (
        input  valid_in, data_in, last_in,
        output in_ready, valid_out, data_out, Chidx_out, Tmax, last_out
    );
endinterface

// File: rtl/tmax_stage_buffer.sv
// Buffers one group of FP16 values, tracks the group maximum, then replays the group
// with its maximum attached. Define TMAX_ABS_EN to compare magnitudes instead of raw bits.
module tmax_stage_buffer #(
    parameter int DEPTH = 64
) (
    input logic           clk,
    input logic           rstn,
    tmax_stage_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state, state_nx;
    logic [15:0]   buffer [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] rd_ptr;
    logic [15:0]   run_max;
    logic [15:0]   cmp_val;
    logic [AW-1:0] wr_idx;
    logic          in_ready_c;
    logic          accept;
    logic          tmax_loaded;
    logic          valid_q;
    logic          last_q;
    logic [15:0]   data_q;
    logic [15:0]   chidx_q;
    logic [15:0]   tmax_q;

`ifdef TMAX_ABS_EN
    assign cmp_val = {1'b0, bus.data_in[14:0]};
`else
    assign cmp_val = bus.data_in;
`endif

    assign accept = bus.valid_in && in_ready_c;
    assign wr_idx = (state == IDLE) ? '0 : count[AW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A group closes on last_in or when the buffer fills; drain ends once the last beat has been shown.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bus.last_in ? DRAIN : FILL;
            FILL:    if (accept && (bus.last_in || count == DEPTH_M1)) state_nx = DRAIN;
            DRAIN:   if (last_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = (state != DRAIN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count   <= '0;
            run_max <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                count   <= CW'(1);
                run_max <= cmp_val;
            end else begin
                count <= count + 1'b1;
                if (cmp_val > run_max) run_max <= cmp_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buffer[wr_idx] <= bus.data_in;
    end

    // First DRAIN cycle freezes Tmax; beats follow back to back until the last one has been presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmax_loaded <= 1'b0;
            rd_ptr      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            chidx_q     <= '0;
            tmax_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (state == DRAIN) begin
                if (!tmax_loaded) begin
                    tmax_q      <= run_max;
                    tmax_loaded <= 1'b1;
                    rd_ptr      <= '0;
                end else if (!last_q) begin
                    valid_q <= 1'b1;
                    data_q  <= buffer[rd_ptr[AW-1:0]];
                    chidx_q <= 16'(rd_ptr);
                    last_q  <= (rd_ptr == count - 1'b1);
                    rd_ptr  <= rd_ptr + 1'b1;
                end else begin
                    tmax_loaded <= 1'b0;
                end
            end else begin
                tmax_loaded <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.data_out  = data_q;
    assign bus.Chidx_out = chidx_q;
    assign bus.Tmax      = tmax_q;
endmodule

// File: tb/tb_tmax_stage_buffer.sv
// Scoreboard bench for tmax_stage_buffer: directed groups push expected beats,
// a negedge monitor pops and compares every presented beat.
`timescale 1ns/1ps
module tb_tmax_stage_buffer;
    typedef struct {
        logic [15:0] data;
        logic [15:0] chidx;
        logic [15:0] tmax;
        logic        last;
        bit          chk_cyc;
        int          exp_cyc;
    } beat_t;

`ifdef TMAX_ABS_EN
    localparam logic [15:0] SIGN_TMAX = 16'h4900;
`else
    localparam logic [15:0] SIGN_TMAX = 16'hC900;
`endif

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   cyc;
    beat_t       sb[$];
    logic [15:0] grp[$];

    tmax_stage_buffer_if bus ();

    tmax_stage_buffer #(.DEPTH(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every beat the DUT presents must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn && bus.valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat actual data=0x%0h chidx=%0d required no beat",
                         bus.data_out, bus.Chidx_out);
            end else begin
                beat_t b;
                b = sb.pop_front();
                checkOutput("beat_data",  bus.data_out,  b.data);
                checkOutput("beat_chidx", bus.Chidx_out, b.chidx);
                checkOutput("beat_tmax",  bus.Tmax,      b.tmax);
                checkOutput("beat_last",  bus.last_out,  b.last);
                if (b.chk_cyc) checkOutput("first_beat_latency", cyc, b.exp_cyc);
            end
        end
    end

    task automatic driveGroup(input bit use_last, input logic [15:0] exp_tmax);
        int n;
        int close_n;
        n = grp.size();
        close_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b1;
            bus.data_in  = grp[i];
            bus.last_in  = use_last && (i == n - 1);
            if (i == n - 1) close_n = cyc;
            #1;
            checkOutput("in_ready_accept", bus.in_ready, 1);
        end
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data    = grp[i];
            b.chidx   = 16'(i);
            b.tmax    = exp_tmax;
            b.last    = (i == n - 1);
            b.chk_cyc = (i == 0);
            b.exp_cyc = close_n + 3;
            sb.push_back(b);
        end
    endtask

    task automatic applyStimulus(input bit use_last, input logic [15:0] exp_tmax, input bit hold_junk);
        int  n;
        bit  done;
        n = grp.size();
        done = 1'b0;
        driveGroup(use_last, exp_tmax);
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            #1;
            if (hold_junk && sb.size() > 0) begin
                bus.valid_in = 1'b1;
                bus.data_in  = 16'h7BFF;
                bus.last_in  = 1'b0;
                checkOutput("in_ready_drain", bus.in_ready, 0);
            end else begin
                bus.valid_in = 1'b0;
                bus.last_in  = 1'b0;
            end
            if (sb.size() == 0) done = 1'b1;
        end
        bus.valid_in = 1'b0;
        if (!done) checkOutput("drain_timeout", sb.size(), 0);
        @(negedge clk);
        #1;
        checkOutput("in_ready_after", bus.in_ready, 1);
        checkOutput("valid_idle", bus.valid_out, 0);
        checkOutput("last_idle", bus.last_out, 0);
        checkOutput("data_hold", bus.data_out, grp[n-1]);
        checkOutput("chidx_hold", bus.Chidx_out, n - 1);
    endtask

    initial begin
        bit done;
        checks = 0;
        failures = 0;
        cyc = 0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.last_in  = 1'b0;
        rstn = 1'b0;
        #23;
        checkOutput("rst_valid", bus.valid_out, 0);
        checkOutput("rst_last",  bus.last_out, 0);
        checkOutput("rst_data",  bus.data_out, 0);
        checkOutput("rst_chidx", bus.Chidx_out, 0);
        checkOutput("rst_tmax",  bus.Tmax, 0);
        checkOutput("rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;

        grp = '{16'h3C00, 16'h4800, 16'h4000};
        applyStimulus(1'b1, 16'h4800, 1'b0);

        grp = '{16'h3555};
        applyStimulus(1'b1, 16'h3555, 1'b0);

        grp.delete();
        for (int i = 1; i <= 64; i++) grp.push_back(16'(i));
        applyStimulus(1'b0, 16'h0040, 1'b0);

        grp = '{16'hC900, 16'h4800};
        applyStimulus(1'b1, SIGN_TMAX, 1'b0);

        grp = '{16'h1234, 16'h0F00};
        applyStimulus(1'b1, 16'h1234, 1'b1);

        grp = '{16'h0800, 16'h0900};
        applyStimulus(1'b1, 16'h0900, 1'b0);

        grp = '{16'h4400, 16'h4400, 16'h4100};
        applyStimulus(1'b1, 16'h4400, 1'b0);

        // Reset while beat 1 of 3 is on the outputs.
        grp = '{16'h1111, 16'h2222, 16'h3333};
        driveGroup(1'b1, 16'h3333);
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            #1;
            bus.valid_in = 1'b0;
            bus.last_in  = 1'b0;
            if (sb.size() == 1) done = 1'b1;
        end
        if (!done) checkOutput("reset_wait_timeout", sb.size(), 1);
        checkOutput("pre_reset_chidx", bus.Chidx_out, 1);
        rstn = 1'b0;
        #1;
        checkOutput("reset_valid", bus.valid_out, 0);
        checkOutput("reset_ready", bus.in_ready, 1);
        checkOutput("reset_tmax",  bus.Tmax, 0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            checkOutput("post_reset_valid", bus.valid_out, 0);
        end
        checkOutput("post_reset_ready", bus.in_ready, 1);

        grp = '{16'h3800};
        applyStimulus(1'b1, 16'h3800, 1'b0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
